// File: rtl/bip_pkg.sv
// Opcode map, datapath select encodings, FSM states and opcode classification
// shared by the bip_ctrl sequencer and its decoder.
package bip_pkg;

    localparam logic [3:0] OP_HLT  = 4'd0;
    localparam logic [3:0] OP_STO  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_LDI  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SUBI = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_ANDI = 4'd9;
    localparam logic [3:0] OP_OR   = 4'd10;
    localparam logic [3:0] OP_ORI  = 4'd11;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic is_mem_rd;
        logic is_alu;
        logic is_imm;
        logic is_store;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

    // high_set flags any opcode bit above bit 3, which is always illegal
    function automatic logic code_illegal(input logic [3:0] low, input logic high_set);
        return high_set || (low > OP_ORI);
    endfunction

    // ALU ops come in pairs: even code reads RAM, odd code is the immediate form
    function automatic logic code_mem_rd(input logic [3:0] low);
        return (low == OP_LD) || ((low >= OP_ADD) && (low <= OP_ORI) && !low[0]);
    endfunction

    function automatic op_class_t classify(input logic [3:0] low, input logic high_set);
        op_class_t c;
        c = '0;
        if (code_illegal(low, high_set)) begin
            c.is_illegal = 1'b1;
        end else begin
            c.is_mem_rd = code_mem_rd(low);
            case (low)
                OP_HLT:  c.is_halt  = 1'b1;
                OP_STO:  c.is_store = 1'b1;
                OP_LD:   c.is_imm   = 1'b0;
                OP_LDI:  c.is_imm   = 1'b1;
                default: begin
                    c.is_alu = 1'b1;
                    c.is_imm = low[0];
                end
            endcase
        end
        return c;
    endfunction

    function automatic logic [1:0] alu_op_of(input logic [3:0] code);
        case (code)
            OP_SUB, OP_SUBI: return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/bip_op_dec.sv
// Combinational decode of the latched opcode into instruction class flags.
module bip_op_dec
    import bip_pkg::*;
#(
    parameter int OPBTS = 5
) (
    input  logic [OPBTS-1:0] op_code,
    output logic             is_mem_rd,
    output logic             is_alu,
    output logic             is_imm,
    output logic             is_store,
    output logic             is_halt,
    output logic             is_illegal
);

    op_class_t cls;

    assign cls = classify(op_code[3:0], op_code > OPBTS'(15));

    assign is_mem_rd  = cls.is_mem_rd;
    assign is_alu     = cls.is_alu;
    assign is_imm     = cls.is_imm;
    assign is_store   = cls.is_store;
    assign is_halt    = cls.is_halt;
    assign is_illegal = cls.is_illegal;

endmodule

// File: rtl/bip_ctrl.sv
// Instruction sequencer for a small accumulator machine: decodes one opcode at a
// time, waits out the data-RAM read latency and strobes the datapath.
//
//   state     | meaning
//   ST_IDLE   | waiting for i_start
//   ST_DECODE | latch i_op_code, pick next phase
//   ST_READ   | RAM read in flight, RAM_LAT cycles
//   ST_EXEC   | single-cycle write-back and PC increment
//   ST_HALT   | terminal, left only by reset
module bip_ctrl
    import bip_pkg::*;
#(
    parameter int OPBTS    = 5,
    parameter int RAM_LAT  = 1,
    parameter int CNTBTS   = 16,
    parameter bit ILL_HALT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [OPBTS-1:0]  i_op_code,
    output logic [1:0]        o_sel_A,
    output logic              o_sel_B,
    output logic [1:0]        o_op,
    output logic              o_w_acc,
    output logic              o_w_ram,
    output logic              o_r_ram,
    output logic              o_w_pc,
    output logic              o_halted,
    output logic              o_illegal,
    output logic [CNTBTS-1:0] o_cycle_cnt
);

    state_t           state, state_nxt;
    logic [OPBTS-1:0] op_q;
    logic [1:0]       rd_cnt;
    logic             halt_entry;
    logic             q_mem_rd, q_alu, q_imm, q_store, q_halt, q_illegal;
    logic             in_high, in_halt, in_mem_rd, in_illegal;

    bip_op_dec #(.OPBTS(OPBTS)) u_dec (
        .op_code    (op_q),
        .is_mem_rd  (q_mem_rd),
        .is_alu     (q_alu),
        .is_imm     (q_imm),
        .is_store   (q_store),
        .is_halt    (q_halt),
        .is_illegal (q_illegal)
    );

    // Branch decision in DECODE must see the live opcode, before it is latched
    assign in_high    = i_op_code > OPBTS'(15);
    assign in_illegal = code_illegal(i_op_code[3:0], in_high);
    assign in_halt    = !in_high && (i_op_code[3:0] == OP_HLT);
    assign in_mem_rd  = !in_high && code_mem_rd(i_op_code[3:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q        <= '0;
            rd_cnt      <= '0;
            halt_entry  <= 1'b0;
            o_cycle_cnt <= '0;
        end else begin
            if (state == ST_DECODE) op_q <= i_op_code;
            if (state == ST_DECODE && state_nxt == ST_READ) rd_cnt <= 2'(RAM_LAT - 1);
            else if (state == ST_READ && rd_cnt != 2'd0)    rd_cnt <= rd_cnt - 2'd1;
            halt_entry <= (state == ST_DECODE) && (state_nxt == ST_HALT);
            if ((state == ST_DECODE || state == ST_READ || state == ST_EXEC) && (o_cycle_cnt != '1))
                o_cycle_cnt <= o_cycle_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_start) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (in_halt || (ILL_HALT && in_illegal)) state_nxt = ST_HALT;
                else if (in_mem_rd)                       state_nxt = ST_READ;
                else                                      state_nxt = ST_EXEC;
            end
            ST_READ:   if (rd_cnt == 2'd0) state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_DECODE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_sel_A   = SELA_RAM;
        o_sel_B   = 1'b0;
        o_op      = ALU_ADD;
        o_w_acc   = 1'b0;
        o_w_ram   = 1'b0;
        o_r_ram   = 1'b0;
        o_w_pc    = 1'b0;
        o_halted  = 1'b0;
        o_illegal = 1'b0;
        if (state == ST_READ || state == ST_EXEC) begin
            if (q_alu) begin
                o_sel_A = SELA_ALU;
                o_sel_B = q_imm;
                o_op    = alu_op_of(op_q[3:0]);
            end else if (q_imm) begin
                o_sel_A = SELA_IMM;
            end
        end
        case (state)
            ST_READ: o_r_ram = 1'b1;
            ST_EXEC: begin
                o_w_pc    = 1'b1;
                o_w_acc   = q_alu || q_mem_rd || q_imm;
                o_w_ram   = q_store;
                o_illegal = q_illegal;
            end
            ST_HALT: begin
                o_halted  = 1'b1;
                // HALT is reached via HLT or an illegal opcode; flag only the latter
                o_illegal = halt_entry && !q_halt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bip_ctrl.sv
// Randomized instruction streams on two bip_ctrl configurations, compared cycle by
// cycle against an instruction-level model of the expected strobe sequence.
module tb_bip_ctrl;

    localparam int PH_IDLE = 0, PH_READ = 1, PH_EXEC = 2, PH_HALT0 = 3, PH_HALT = 4;

    logic       clk = 1'b0;
    logic       rst   [2] = '{1'b1, 1'b1};
    logic       start [2] = '{1'b0, 1'b0};
    logic [4:0] opc   [2] = '{5'd0, 5'd0};
    logic [1:0] sel_a [2];
    logic       sel_b [2];
    logic [1:0] aop   [2];
    logic       w_acc [2], w_ram [2], r_ram [2], w_pc [2], halted [2], illegal [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    bip_ctrl #(.OPBTS(5), .RAM_LAT(1), .CNTBTS(16), .ILL_HALT(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_op_code(opc[0]),
        .o_sel_A(sel_a[0]), .o_sel_B(sel_b[0]), .o_op(aop[0]),
        .o_w_acc(w_acc[0]), .o_w_ram(w_ram[0]), .o_r_ram(r_ram[0]), .o_w_pc(w_pc[0]),
        .o_halted(halted[0]), .o_illegal(illegal[0]), .o_cycle_cnt(cnt0)
    );

    bip_ctrl #(.OPBTS(5), .RAM_LAT(3), .CNTBTS(4), .ILL_HALT(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_op_code(opc[1]),
        .o_sel_A(sel_a[1]), .o_sel_B(sel_b[1]), .o_op(aop[1]),
        .o_w_acc(w_acc[1]), .o_w_ram(w_ram[1]), .o_r_ram(r_ram[1]), .o_w_pc(w_pc[1]),
        .o_halted(halted[1]), .o_illegal(illegal[1]), .o_cycle_cnt(cnt1)
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit ill_halt_of(input int k);
        return k == 1;
    endfunction

    function automatic int cap_of(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic int cnt_of(input int k);
        return (k == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // Packed as {sel_A, sel_B, op, w_acc, w_ram, r_ram, w_pc, halted, illegal}
    function automatic logic [10:0] obs(input int k);
        return {sel_a[k], sel_b[k], aop[k], w_acc[k], w_ram[k], r_ram[k], w_pc[k], halted[k], illegal[k]};
    endfunction

    function automatic bit is_mem_rd(input int v);
        return (v == 2) || (v >= 4 && v <= 11 && (v % 2) == 0);
    endfunction

    function automatic logic [10:0] expect_vec(input int v, input int ph);
        logic [1:0] sa = 2'b00;
        logic       sb = 1'b0;
        logic [1:0] op = 2'b00;
        logic       wa = 1'b0, wr = 1'b0, rr = 1'b0, wp = 1'b0, h = 1'b0, il = 1'b0;
        bit legal = (v <= 11);
        bit alu   = legal && (v >= 4);
        if (ph == PH_READ || ph == PH_EXEC) begin
            if (v == 3) sa = 2'b01;
            if (alu) begin
                sa = 2'b10;
                sb = (v % 2) == 1;
                op = 2'((v - 4) / 2);
            end
        end
        case (ph)
            PH_READ: rr = 1'b1;
            PH_EXEC: begin
                wp = 1'b1;
                wa = legal && (v >= 2);
                wr = (v == 1);
                il = !legal;
            end
            PH_HALT0: begin
                h  = 1'b1;
                il = (v != 0);
            end
            PH_HALT: h = 1'b1;
            default: ;
        endcase
        return {sa, sb, op, wa, wr, rr, wp, h, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input int k, input string tag, input logic [10:0] v);
        chk($sformatf("i%0d %s outs", k, tag), 32'(obs(k)), 32'(v));
        chk($sformatf("i%0d %s cnt", k, tag), cnt_of(k), exp_cnt[k]);
    endtask

    task automatic bump(input int k);
        if (exp_cnt[k] < cap_of(k)) exp_cnt[k]++;
    endtask

    task automatic scramble(input int k);
        opc[k]   = 5'($urandom);
        start[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int k);
        rst[k]   = 1'b1;
        start[k] = 1'b0;
        opc[k]   = 5'($urandom);
        tick();
        tick();
        exp_cnt[k] = 0;
        check_cycle(k, "reset", '0);
        rst[k] = 1'b0;
        tick();
        check_cycle(k, "idle", '0);
    endtask

    task automatic launch(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'($urandom_range(0, 1));
    endtask

    // Entered with the DUT in DECODE; leaves it in DECODE again or halted.
    task automatic run_instr(input int k, input int v, output bit halt_out);
        opc[k] = 5'(v);
        check_cycle(k, $sformatf("decode op%0d", v), '0);
        tick();
        bump(k);
        scramble(k);
        halt_out = 1'b0;
        if (v == 0 || (v > 11 && ill_halt_of(k))) begin
            check_cycle(k, $sformatf("halt0 op%0d", v), expect_vec(v, PH_HALT0));
            for (int c = 0; c < 19; c++) begin
                tick();
                scramble(k);
                check_cycle(k, $sformatf("halt op%0d", v), expect_vec(v, PH_HALT));
            end
            halt_out = 1'b1;
            return;
        end
        if (is_mem_rd(v)) begin
            for (int c = 0; c < lat_of(k); c++) begin
                check_cycle(k, $sformatf("read%0d op%0d", c, v), expect_vec(v, PH_READ));
                tick();
                bump(k);
                scramble(k);
            end
        end
        check_cycle(k, $sformatf("exec op%0d", v), expect_vec(v, PH_EXEC));
        tick();
        bump(k);
        scramble(k);
        start[k] = 1'b1;
    endtask

    initial begin
        bit h;
        int v;

        // LDI first, then STO, illegal-as-NOP, ADD, and HLT held under start pulses
        do_reset(0);
        launch(0);
        run_instr(0, 3, h);
        chk("i0 ldi cycle_cnt", cnt_of(0), 2);
        run_instr(0, 1, h);
        run_instr(0, 15, h);
        run_instr(0, 4, h);
        run_instr(0, 0, h);

        // ADD with three-cycle RAM, then illegal opcode halts this configuration
        do_reset(1);
        launch(1);
        run_instr(1, 4, h);
        chk("i1 add latency", cnt_of(1), 5);
        run_instr(1, 15, h);

        // Reset landing in the second READ cycle of LD
        do_reset(1);
        launch(1);
        opc[1] = 5'd2;
        check_cycle(1, "ld decode", '0);
        tick(); bump(1); scramble(1);
        check_cycle(1, "ld read0", expect_vec(2, PH_READ));
        tick(); bump(1); scramble(1);
        check_cycle(1, "ld read1", expect_vec(2, PH_READ));
        rst[1]   = 1'b1;
        start[1] = 1'b0;
        tick();
        exp_cnt[1] = 0;
        check_cycle(1, "rst midread", '0);
        rst[1] = 1'b0;
        tick();
        check_cycle(1, "idle after rst", '0);

        // Four-bit counter saturates over ten ADDI instructions
        launch(1);
        for (int n = 0; n < 10; n++) run_instr(1, 5, h);
        chk("i1 cnt saturate", cnt_of(1), 15);

        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 6; r++) begin
                do_reset(k);
                launch(k);
                for (int n = 0; n < 14; n++) begin
                    case ($urandom_range(0, 9))
                        0:       v = int'($urandom_range(12, 31));
                        1:       v = (n > 8) ? 0 : int'($urandom_range(1, 11));
                        default: v = int'($urandom_range(1, 11));
                    endcase
                    run_instr(k, v, h);
                    if (h) break;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bip_ctrl.md
BIP_CTRL -- requirements
Module: bip_ctrl

Interface
REQ-001 Parameter OPBTS, default 5, opcode width; SHALL be at least 4.
REQ-002 Parameter RAM_LAT, default 1, data-RAM read latency in cycles; legal range 1..4.
REQ-003 Parameter CNTBTS, default 16, width of the cycle counter.
REQ-004 Parameter ILL_HALT, default 0; 1 makes an illegal opcode halt the block, 0 makes it execute as a NOP.
REQ-005 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-006 i_rst  in  1  reset; synchronous, active-high.
REQ-007 i_start  in  1  level/pulse; starts execution from IDLE.
REQ-008 i_op_code  in  OPBTS  opcode of the current instruction; sampled in DECODE only.
REQ-009 o_sel_A  out  2  accumulator input mux: 00 RAM data, 01 immediate, 10 ALU result.
REQ-010 o_sel_B  out  1  ALU operand B: 0 RAM data, 1 immediate.
REQ-011 o_op  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-012 o_w_acc / o_w_ram / o_r_ram / o_w_pc  out  1 each  accumulator write, RAM write, RAM read, PC increment strobes.
REQ-013 o_halted  out  1  high while in HALT.
REQ-014 o_illegal  out  1  one-cycle pulse on an illegal opcode.
REQ-015 o_cycle_cnt  out  CNTBTS  number of executed cycles.

Function
REQ-016 Opcode map: 0 HLT, 1 STO, 2 LD, 3 LDI, 4 ADD, 5 ADDI, 6 SUB, 7 SUBI, 8 AND, 9 ANDI, 10 OR, 11 ORI; every other value is illegal.
REQ-017 Memory-read ops: LD, ADD, SUB, AND, OR; all others perform no RAM read.
REQ-018 FSM states: IDLE, DECODE, READ, EXEC, HALT.
REQ-019 IDLE: goes to DECODE when i_start=1; otherwise stays in IDLE.
REQ-020 DECODE: latches i_op_code into the internal opcode register and branches as follows.
  - HLT -> HALT.
  - Memory-read op -> READ.
  - All other opcodes, including illegal ones -> EXEC; with ILL_HALT=1 an illegal opcode goes to HALT instead.
REQ-021 READ: o_r_ram=1 for exactly RAM_LAT consecutive cycles via a down-counter, then EXEC.
REQ-022 EXEC: lasts exactly one cycle, then DECODE.
  - o_w_pc=1.
  - o_w_acc=1 for LD, LDI and all ALU ops.
  - o_w_ram=1 for STO only.
REQ-023 All outputs are Moore outputs: decoded from the state and the latched opcode, with no combinational path from i_op_code or i_start.
REQ-024 o_sel_A, o_sel_B and o_op are driven from the latched opcode in READ and EXEC, and are 0 in IDLE, DECODE and HALT.
  - LD: sel_A=00.
  - LDI: sel_A=01.
  - ALU ops: sel_A=10; sel_B=1 for the immediate forms.
REQ-025 Instruction latency: 2 cycles for non-read ops; 2+RAM_LAT cycles for memory-read ops.
REQ-026 o_illegal pulses for one cycle in the cycle after DECODE, in EXEC or on entry to HALT; with ILL_HALT=0, EXEC then asserts only o_w_pc.
REQ-027 HALT is terminal: all strobes 0, o_halted=1, i_start ignored; HALT is left only by reset.
REQ-028 o_cycle_cnt increments once per cycle in DECODE, READ and EXEC, and saturates at all-ones (no wrap).
REQ-029 i_start while not in IDLE is ignored.
REQ-030 i_op_code changes outside DECODE have no effect.

Reset
REQ-031 While i_rst=1 the state is IDLE, with:
  - opcode register 0;
  - READ counter 0;
  - o_cycle_cnt 0;
  - all outputs 0.
REQ-032 Reset has priority over every transition, including mid-READ and in HALT; execution resumes only on a new i_start.

Structure
REQ-033 Shared package bip_pkg SHALL contain:
  - opcode localparams;
  - sel_A and ALU-op encodings;
  - FSM state encoding.
REQ-034 Sub-module bip_op_dec SHALL be the combinational decode from latched opcode to class flags: is_mem_rd, is_alu, is_imm, is_store, is_halt, is_illegal.

Verification
REQ-035 Reset, i_start=1, op=3 (LDI) -> DECODE then EXEC with sel_A=01, w_acc=1, w_pc=1; cycle_cnt=2.
REQ-036 RAM_LAT=3, op=4 (ADD) -> r_ram=1 for 3 cycles; EXEC with sel_A=10, sel_B=0, op=00, w_acc=1; latency 5.
REQ-037 op=1 (STO) -> w_ram=1, w_acc=0 in EXEC; then op=0 (HLT) -> o_halted=1 held 20 cycles despite i_start pulses.
REQ-038 op=15 with ILL_HALT=0 -> o_illegal pulse, only w_pc in EXEC; with ILL_HALT=1 -> HALT, o_illegal pulse.
REQ-039 i_rst=1 during the second READ cycle of LD (RAM_LAT=3) -> next cycle IDLE, all outputs 0, cycle_cnt=0.
REQ-040 CNTBTS=4, run 20 cycles of ADDI -> o_cycle_cnt stops at 15.
